// File: rtl/logicx_multi_pkg.sv
// Shared types and helpers for the multi-button LED block.
// Mode encodings and counter-width helper live here so top and channels agree.
package logicx_multi_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL   = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_STRETCH = 2'b10,
        MODE_BLANK   = 2'b11
    } mode_e;

    // One extra bit over clog2 so the terminal count always fits.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/logicx_multi_btn_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debouncer and
// registered rising-edge strobe of the debounced level.
module btn_debounce
    import logicx_multi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff    <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_ff    <= {sync_ff[0], din};
            level_d    <= level;
            rise_pulse <= level & ~level_d;
            // Count consecutive mismatches; any agreeing cycle restarts the count.
            if (sync_ff[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_ff[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/logicx_multi.sv
// N-channel button-to-LED block: debounced channels feed toggle latches and
// pulse stretchers; a synchronised mode switch picks what each LED shows.
module logicx_multi
    import logicx_multi_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    input  logic [1:0]       mode,
    output logic [N_BTN-1:0] led,
    output logic             led_and,
    output logic             led_or,
    output logic [N_BTN-1:0] press
);

    localparam int            PW         = cnt_width(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

    logic [N_BTN-1:0]         stable;
    logic [N_BTN-1:0]         toggle;
    logic [N_BTN-1:0][PW-1:0] stretch_cnt;
    logic [N_BTN-1:0]         led_nxt;
    logic [1:0]               mode_meta;
    logic [1:0]               mode_q;
    mode_e                    mode_s;

    assign mode_s = mode_e'(mode_q);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (btn[i]),
            .level     (stable[i]),
            .rise_pulse(press[i])
        );
    end

    always_comb begin
        led_nxt = '0;
        case (mode_s)
            MODE_LEVEL:   led_nxt = stable;
            MODE_TOGGLE:  led_nxt = toggle;
            MODE_STRETCH: begin
                for (int i = 0; i < N_BTN; i++) led_nxt[i] = (stretch_cnt[i] != '0);
            end
            default:      led_nxt = '0;
        endcase
    end

    // Latches and stretchers run in every mode so switching never loses state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta   <= '0;
            mode_q      <= '0;
            toggle      <= '0;
            stretch_cnt <= '0;
            led         <= '0;
        end else begin
            mode_meta <= mode;
            mode_q    <= mode_meta;
            toggle    <= toggle ^ press;
            led       <= led_nxt;
            for (int i = 0; i < N_BTN; i++) begin
                if (press[i])
                    stretch_cnt[i] <= PULSE_LOAD;
                else if (stretch_cnt[i] != '0)
                    stretch_cnt[i] <= stretch_cnt[i] - PW'(1);
            end
        end
    end

    assign led_and = &led;
    assign led_or  = |led;

endmodule
